// File: rtl/fetch_pkg.sv
// Shared types for the fetch/sequencing unit: run-state encoding, default PC type
// and the next-PC source selection with its priority resolver.
package fetch_pkg;

  localparam int unsigned PC_W = 12;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NPC_INC    = 3'd0,
    NPC_RET    = 3'd1,
    NPC_CALL   = 3'd2,
    NPC_JUMP   = 3'd3,
    NPC_BRANCH = 3'd4
  } npc_sel_t;

  // ret > call > jump > taken branch > sequential
  function automatic npc_sel_t npc_select(input logic ret, input logic call,
                                          input logic jump, input logic taken);
    if (ret)       return NPC_RET;
    else if (call) return NPC_CALL;
    else if (jump) return NPC_JUMP;
    else if (taken) return NPC_BRANCH;
    else           return NPC_INC;
  endfunction

endpackage

// File: rtl/fetch_ctrl_ras_stack.sv
// Return-address LIFO. Push when full and pop when empty are ignored; the
// parent flags those cases itself. Push and pop never arrive together.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  mem [DEPTH];

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt) mem[i] <= din;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == cnt) top = mem[i];
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/sequencing unit: IDLE/RUN/DONE run control, next-PC selection with
// call/return stack, registered ALU flags and executed-instruction counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned D          = 12,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 128,
  parameter int unsigned RAS_DEPTH  = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [D-1:0]     target,
  input  logic             zero_i,
  input  logic             pari_i,
  input  logic             sc_i,
  input  logic             sc_clr,
  input  logic             sc_en,
  output logic [D-1:0]     prog_ctr,
  output logic             fetch_valid,
  output logic             done,
  output logic             zero_q,
  output logic             pari_q,
  output logic             sc_q,
  output logic             ras_ovf,
  output logic             ras_unf,
  output logic [CNT_W-1:0] icount
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  localparam logic [D-1:0] END_PC   = D'(END_ADDR);

  state_t       state_q, state_d;
  npc_sel_t     sel;
  logic [D-1:0] pc_inc, pc_nxt, stk_top;
  logic         exec, start, stk_full, stk_empty, ras_push, ras_pop;

  assign fetch_valid = (state_q == RUN) && !stall;
  // An abort (req low in RUN) takes precedence over executing the current PC.
  assign exec        = fetch_valid && req;
  assign start       = (state_q == IDLE) && req;
  assign done        = (state_q == DONE);
  assign pc_inc      = prog_ctr + 1'b1;
  assign sel         = npc_select(ret_en, call_en, jump_en, branch_en && zero_i);
  assign ras_push    = exec && (sel == NPC_CALL) && !stk_full;
  assign ras_pop     = exec && (sel == NPC_RET) && !stk_empty;

  always_comb begin
    pc_nxt = pc_inc;
    case (sel)
      NPC_RET:                        if (!stk_empty) pc_nxt = stk_top;
      NPC_CALL, NPC_JUMP, NPC_BRANCH: pc_nxt = target;
      default:                        pc_nxt = pc_inc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = RUN;
      RUN: begin
        if (!req)                          state_d = IDLE;
        else if (exec && pc_nxt == END_PC) state_d = DONE;
      end
      DONE:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      prog_ctr <= START_PC;
      zero_q   <= 1'b0;
      pari_q   <= 1'b0;
      sc_q     <= 1'b0;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
      icount   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        prog_ctr <= START_PC;
        icount   <= '0;
        ras_ovf  <= 1'b0;
        ras_unf  <= 1'b0;
      end else if (exec) begin
        prog_ctr <= pc_nxt;
        zero_q   <= zero_i;
        pari_q   <= pari_i;
        if (sc_clr)     sc_q <= 1'b0;
        else if (sc_en) sc_q <= sc_i;
        if (icount != '1) icount <= icount + 1'b1;
        if (sel == NPC_CALL && stk_full) ras_ovf <= 1'b1;
        if (sel == NPC_RET && stk_empty) ras_unf <= 1'b1;
      end
    end
  end

  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (D)
  ) u_ras (
    .clk  (clk),
    .reset(reset),
    .clr  (start),
    .push (ras_push),
    .pop  (ras_pop),
    .din  (pc_inc),
    .top  (stk_top),
    .full (stk_full),
    .empty(stk_empty)
  );

endmodule
